// File: rtl/gate_array_pkg.sv
// gate_array_pkg: opcode/reduction enums and per-lane helper functions
package gate_array_pkg;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_PASS_A, OP_NOT_A
  } op_e;
  typedef enum logic [1:0] {RED_AND, RED_OR, RED_XOR, RED_XNOR} red_e;
  function automatic op_e default_op(input int i);
    return (i % 3 == 0) ? OP_OR : (i % 3 == 1) ? OP_NAND : OP_NOR;
  endfunction
  function automatic logic apply_op(input op_e op, input logic a, input logic b);
    case (op)
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_NAND:   return ~(a & b);
      OP_NOR:    return ~(a | b);
      OP_XOR:    return a ^ b;
      OP_XNOR:   return ~(a ^ b);
      OP_PASS_A: return a;
      default:   return ~a;
    endcase
  endfunction
endpackage

// File: rtl/gate_array_reducer_if.sv
// gate_array_reducer_if: operand input and result output valid/ready channels
//   in_valid/in_ready/a/b/red_mode : input beat (master drives, slave accepts)
//   out_valid/out_ready/lanes/saida : result beat (slave presents, master consumes)
interface gate_array_reducer_if #(parameter int WIDTH = 3);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       red_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] lanes;
  logic             saida;
  modport master (
    output in_valid, a, b, red_mode, out_ready,
    input  in_ready, out_valid, lanes, saida
  );
  modport slave (
    input  in_valid, a, b, red_mode, out_ready,
    output in_ready, out_valid, lanes, saida
  );
endinterface

// File: rtl/gate_lane.sv
// gate_lane: combinational 1-bit programmable gate
//   op : opcode, a/b : operand bits, y : result
module gate_lane
  import gate_array_pkg::*;
(
  input  op_e  op,
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = apply_op(op, a, b);
endmodule

// File: rtl/gate_array_reducer.sv
// gate_array_reducer: programmable per-lane gate array with reduction, 2-stage valid/ready pipeline
//   clk/rst              : clock, synchronous active-high reset
//   cfg_we/cfg_lane/cfg_op : op table write port (out-of-range lane ignored)
//   bus (slave)          : a/b/red_mode input beat, lanes/saida result beat
//   hit_count            : delivered beats with saida=1, saturating (only with HIT_COUNTER_EN)
module gate_array_reducer
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8,
  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [LW-1:0]       cfg_lane,
  input  logic [2:0]          cfg_op,
  gate_array_reducer_if.slave bus,
  output logic [CNT_W-1:0]    hit_count
);
  op_e              op_tbl [WIDTH];
  logic [WIDTH-1:0] lane_res;
  logic [WIDTH-1:0] s1_lanes;
  logic [WIDTH-1:0] s2_lanes;
  red_e             s1_red;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_saida;
  logic             s2_load;
  logic             red_out;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    always_ff @(posedge clk)
      if (rst) op_tbl[i] <= default_op(i);
      else if (cfg_we && cfg_lane == LW'(i)) op_tbl[i] <= op_e'(cfg_op);
    gate_lane u_lane (.op(op_tbl[i]), .a(bus.a[i]), .b(bus.b[i]), .y(lane_res[i]));
  end
  assign s2_load      = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s2_load;
  assign bus.out_valid = s2_valid;
  assign bus.lanes    = s2_lanes;
  assign bus.saida    = s2_saida;
  always_comb
    red_out = (s1_red == RED_AND) ? &s1_lanes :
              (s1_red == RED_OR)  ? |s1_lanes :
              (s1_red == RED_XOR) ? ^s1_lanes : ~^s1_lanes;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_lanes <= '0;
      s1_red   <= RED_AND;
      s2_lanes <= '0;
      s2_saida <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (bus.in_valid && bus.in_ready) begin
        s1_lanes <= lane_res;
        s1_red   <= red_e'(bus.red_mode);
      end
      // an empty or draining S2 takes whatever S1 holds, valid or not
      if (bus.out_ready || !s2_valid) s2_valid <= s1_valid;
      if (s2_load) begin
        s2_lanes <= s1_lanes;
        s2_saida <= red_out;
      end
    end
  end
`ifdef HIT_COUNTER_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (s2_valid && bus.out_ready && s2_saida && !(&cnt)) cnt <= cnt + 1'b1;
  assign hit_count = cnt;
`else
  assign hit_count = '0;
`endif
endmodule
